// File: rtl/dma_scheduler.sv
// dma_scheduler: two-requester round-robin front end for a register-programmed
// DMA engine. Ports:
//   clock, clock_sreset          - rising-edge clock, synchronous active-high reset
//   rq_req[1:0]                  - level requests, held until the matching rq_done
//   rq_src*/rq_dst*/rq_count*    - per-requester source, destination, word count
//   rq_done[1:0], rq_err[1:0]    - one-cycle completion pulse and error qualifier
//   busy, grant                  - FSM not idle; current/last granted requester
//   m_address/m_writedata/m_write/m_waitrequest - DMA register write master
//   dma_irq                      - DMA completion interrupt (level)
module dma_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clock,
    input  logic        clock_sreset,
    input  logic [1:0]  rq_req,
    input  logic [31:0] rq_src0,
    input  logic [31:0] rq_src1,
    input  logic [31:0] rq_dst0,
    input  logic [31:0] rq_dst1,
    input  logic [31:0] rq_count0,
    input  logic [31:0] rq_count1,
    output logic [1:0]  rq_done,
    output logic [1:0]  rq_err,
    output logic        busy,
    output logic        grant,
    output logic [3:0]  m_address,
    output logic [31:0] m_writedata,
    output logic        m_write,
    input  logic        m_waitrequest,
    input  logic        dma_irq
);

    localparam logic [3:0] A_CTRL = 4'd0;
    localparam logic [3:0] A_CMD  = 4'd1;
    localparam logic [3:0] A_SRC  = 4'd2;
    localparam logic [3:0] A_DST  = 4'd3;
    localparam logic [3:0] A_CNT  = 4'd4;

    typedef enum logic [3:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_CNT,
        WR_GO,
        WAIT_IRQ,
        WR_CLR,
        ABORT_RST,
        ABORT_CLR,
        WAIT_CLR,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        prio_q, prio_d;
    logic        err_q, err_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;

    logic        pick;
    logic [31:0] cnt_sel;

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        err_d       = err_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        rq_done     = 2'b00;
        rq_err      = 2'b00;
        m_write     = 1'b0;
        m_address   = 4'd0;
        m_writedata = 32'd0;
        // prio_q names the requester that wins a tie; a lone request wins outright
        pick        = (rq_req == 2'b11) ? prio_q : rq_req[1];
        cnt_sel     = pick ? rq_count1 : rq_count0;

        unique case (state_q)
            IDLE: begin
                if (rq_req != 2'b00) begin
                    grant_d = pick;
                    prio_d  = ~pick;
                    src_d   = pick ? rq_src1 : rq_src0;
                    dst_d   = pick ? rq_dst1 : rq_dst0;
                    cnt_d   = cnt_sel;
                    err_d   = (cnt_sel == 32'd0);
                    state_d = (cnt_sel == 32'd0) ? DONE : WR_SRC;
                end
            end
            WR_SRC: begin
                m_write     = 1'b1;
                m_address   = A_SRC;
                m_writedata = src_q;
                if (!m_waitrequest) state_d = WR_DST;
            end
            WR_DST: begin
                m_write     = 1'b1;
                m_address   = A_DST;
                m_writedata = dst_q;
                if (!m_waitrequest) state_d = WR_CNT;
            end
            WR_CNT: begin
                m_write     = 1'b1;
                m_address   = A_CNT;
                m_writedata = cnt_q;
                if (!m_waitrequest) state_d = WR_GO;
            end
            WR_GO: begin
                m_write     = 1'b1;
                m_address   = A_CTRL;
                m_writedata = 32'h3;
                if (!m_waitrequest) begin
                    tmo_d   = 32'd0;
                    state_d = WAIT_IRQ;
                end
            end
            WAIT_IRQ: begin
                tmo_d = tmo_q + 32'd1;
                // an interrupt arriving on the timeout cycle still counts as success
                if (dma_irq) begin
                    state_d = WR_CLR;
                end else if (tmo_d >= TIMEOUT_CYCLES) begin
                    err_d   = 1'b1;
                    state_d = ABORT_RST;
                end
            end
            WR_CLR: begin
                m_write     = 1'b1;
                m_address   = A_CMD;
                m_writedata = 32'h2;
                if (!m_waitrequest) state_d = WAIT_CLR;
            end
            ABORT_RST: begin
                m_write     = 1'b1;
                m_address   = A_CMD;
                m_writedata = 32'h1;
                if (!m_waitrequest) state_d = ABORT_CLR;
            end
            ABORT_CLR: begin
                m_write     = 1'b1;
                m_address   = A_CMD;
                m_writedata = 32'h2;
                if (!m_waitrequest) state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!dma_irq) state_d = DONE;
            end
            DONE: begin
                rq_done[grant_q] = 1'b1;
                rq_err[grant_q]  = err_q;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// tb_dma_scheduler: directed self-checking bench for dma_scheduler.
// Inputs change just after the rising edge; writes and done pulses are logged mid-cycle.
module tb_dma_scheduler;

    logic        clock = 1'b0;
    logic        clock_sreset;
    logic [1:0]  rq_req;
    logic [31:0] rq_src0, rq_src1, rq_dst0, rq_dst1, rq_count0, rq_count1;
    logic [1:0]  rq_done, rq_err;
    logic        busy, grant;
    logic [3:0]  m_address;
    logic [31:0] m_writedata;
    logic        m_write;
    logic        m_waitrequest;
    logic        dma_irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          wq_a[$];
    logic [31:0] wq_d[$];
    int          wq_c[$];
    logic [1:0]  dq_b[$];
    logic [1:0]  dq_e[$];
    int          dq_c[$];

    dma_scheduler #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clock(clock), .clock_sreset(clock_sreset), .rq_req(rq_req),
        .rq_src0(rq_src0), .rq_src1(rq_src1),
        .rq_dst0(rq_dst0), .rq_dst1(rq_dst1),
        .rq_count0(rq_count0), .rq_count1(rq_count1),
        .rq_done(rq_done), .rq_err(rq_err), .busy(busy), .grant(grant),
        .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
        .m_waitrequest(m_waitrequest), .dma_irq(dma_irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (m_write && !m_waitrequest) begin
            wq_a.push_back(int'(m_address));
            wq_d.push_back(m_writedata);
            wq_c.push_back(cyc);
        end
        if (rq_done != 2'b00) begin
            dq_b.push_back(rq_done);
            dq_e.push_back(rq_err);
            dq_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        wq_a.delete(); wq_d.delete(); wq_c.delete();
        dq_b.delete(); dq_e.delete(); dq_c.delete();
    endtask

    task automatic wait_writes(input int n, input int lim, output bit ok);
        for (int i = 0; i < lim && wq_a.size() < n; i++) step();
        ok = (wq_a.size() >= n);
    endtask

    task automatic wait_done(input int n, input int lim, output bit ok);
        for (int i = 0; i < lim && dq_b.size() < n; i++) step();
        ok = (dq_b.size() >= n);
    endtask

    task automatic test_reset();
        clock_sreset = 1'b1; rq_req = 2'b00; m_waitrequest = 1'b0; dma_irq = 1'b0;
        rq_src0 = 0; rq_src1 = 0; rq_dst0 = 0; rq_dst1 = 0; rq_count0 = 0; rq_count1 = 0;
        step(); step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0h exp 0", busy); end
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL rst_grant got %0h exp 0", grant); end
        tests++; if (m_write !== 1'b0) begin fails++; $display("FAIL rst_mwrite got %0h exp 0", m_write); end
        tests++; if (m_address !== 4'd0) begin fails++; $display("FAIL rst_maddr got %0h exp 0", m_address); end
        tests++; if (m_writedata !== 32'd0) begin fails++; $display("FAIL rst_mdata got %0h exp 0", m_writedata); end
        tests++; if (rq_done !== 2'b00) begin fails++; $display("FAIL rst_done got %0h exp 0", rq_done); end
        tests++; if (rq_err !== 2'b00) begin fails++; $display("FAIL rst_err got %0h exp 0", rq_err); end
        clock_sreset = 1'b0;
        step();
    endtask

    task automatic test_single();
        int seen;
        bit ok;
        int ea[5];
        logic [31:0] ed[5];
        ea = '{2, 3, 4, 0, 1};
        ed = '{32'h1000, 32'h2000, 32'h4, 32'h3, 32'h2};
        clr();
        rq_src0 = 32'h1000; rq_dst0 = 32'h2000; rq_count0 = 32'd4;
        rq_req = 2'b01; seen = cyc;
        wait_writes(4, 12, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_go_wait got %0d writes exp 4", wq_a.size()); end
        dma_irq = 1'b1; step(); dma_irq = 1'b0;
        wait_done(1, 10, ok);
        rq_req = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL single_done_wait got %0d exp 1", dq_b.size()); end
        tests++; if (wq_a.size() != 5) begin fails++; $display("FAIL single_nwr got %0d exp 5", wq_a.size()); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (wq_a[i] != ea[i] || wq_d[i] !== ed[i]) begin
                fails++; $display("FAIL single_wr%0d got (%0d,%0h) exp (%0d,%0h)", i, wq_a[i], wq_d[i], ea[i], ed[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wq_c[i] != seen + 1 + i) begin
                fails++; $display("FAIL single_cyc%0d got %0d exp %0d", i, wq_c[i], seen + 1 + i);
            end
        end
        tests++; if (dq_b[0] !== 2'b01) begin fails++; $display("FAIL single_done got %0b exp 01", dq_b[0]); end
        tests++; if (dq_e[0] !== 2'b00) begin fails++; $display("FAIL single_err got %0b exp 00", dq_e[0]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got %0b exp 0", busy); end
    endtask

    // requester 0 won last, so a simultaneous request must go to requester 1 first
    task automatic test_tie();
        int seen;
        clr();
        rq_count0 = 32'd0; rq_count1 = 32'd0;
        rq_req = 2'b11; seen = cyc;
        step();
        tests++; if (grant !== 1'b1) begin fails++; $display("FAIL tie_grant1 got %0b exp 1", grant); end
        step(); rq_req = 2'b01;
        step();
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL tie_grant0 got %0b exp 0", grant); end
        step(); rq_req = 2'b00;
        tests++; if (dq_b.size() != 2) begin fails++; $display("FAIL tie_ndone got %0d exp 2", dq_b.size()); end
        tests++; if (dq_b[0] !== 2'b10 || dq_e[0] !== 2'b10 || dq_c[0] != seen + 1) begin
            fails++; $display("FAIL tie_first got %0b/%0b@%0d exp 10/10@%0d", dq_b[0], dq_e[0], dq_c[0], seen + 1);
        end
        tests++; if (dq_b[1] !== 2'b01 || dq_e[1] !== 2'b01 || dq_c[1] != seen + 3) begin
            fails++; $display("FAIL tie_second got %0b/%0b@%0d exp 01/01@%0d", dq_b[1], dq_e[1], dq_c[1], seen + 3);
        end
    endtask

    task automatic test_zero_count();
        int seen;
        bit ok;
        clr();
        rq_count1 = 32'd0; rq_src1 = 32'hA000; rq_dst1 = 32'hB000;
        rq_req = 2'b10; seen = cyc;
        wait_done(1, 6, ok);
        rq_req = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL zero_wait got %0d exp 1", dq_b.size()); end
        tests++; if (dq_b[0] !== 2'b10) begin fails++; $display("FAIL zero_done got %0b exp 10", dq_b[0]); end
        tests++; if (dq_e[0] !== 2'b10) begin fails++; $display("FAIL zero_err got %0b exp 10", dq_e[0]); end
        tests++; if (dq_c[0] != seen + 1) begin fails++; $display("FAIL zero_cyc got %0d exp %0d", dq_c[0], seen + 1); end
        tests++; if (wq_a.size() != 0) begin fails++; $display("FAIL zero_nowr got %0d exp 0", wq_a.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        clr();
        rq_src0 = 32'h3000; rq_dst0 = 32'h4000; rq_count0 = 32'd8;
        rq_req = 2'b01;
        wait_writes(6, 40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL tmo_wait got %0d writes exp 6", wq_a.size()); end
        wait_done(1, 10, ok);
        rq_req = 2'b00;
        tests++; if (!ok) begin fails++; $display("FAIL tmo_done_wait got %0d exp 1", dq_b.size()); end
        tests++; if (wq_a[4] != 1 || wq_d[4] !== 32'h1) begin
            fails++; $display("FAIL tmo_rst got (%0d,%0h) exp (1,1)", wq_a[4], wq_d[4]);
        end
        tests++; if (wq_a[5] != 1 || wq_d[5] !== 32'h2) begin
            fails++; $display("FAIL tmo_clr got (%0d,%0h) exp (1,2)", wq_a[5], wq_d[5]);
        end
        tests++; if (wq_c[4] - wq_c[3] != 17) begin
            fails++; $display("FAIL tmo_delay got %0d exp 17", wq_c[4] - wq_c[3]);
        end
        tests++; if (wq_c[5] != wq_c[4] + 1) begin
            fails++; $display("FAIL tmo_clr_cyc got %0d exp %0d", wq_c[5], wq_c[4] + 1);
        end
        tests++; if (dq_b[0] !== 2'b01 || dq_e[0] !== 2'b01) begin
            fails++; $display("FAIL tmo_done got %0b/%0b exp 01/01", dq_b[0], dq_e[0]);
        end
        tests++; if (dq_c[0] != wq_c[5] + 2) begin
            fails++; $display("FAIL tmo_done_cyc got %0d exp %0d", dq_c[0], wq_c[5] + 2);
        end
    endtask

    task automatic test_waitreq();
        int seen;
        bit ok;
        clr();
        rq_src1 = 32'h5000; rq_dst1 = 32'h6000; rq_count1 = 32'd2;
        rq_req = 2'b10; seen = cyc;
        step(); step();
        m_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (m_write !== 1'b1 || m_address !== 4'd3 || m_writedata !== 32'h6000) begin
                fails++; $display("FAIL wreq_hold%0d got %0b,%0h,%0h exp 1,3,6000", k, m_write, m_address, m_writedata);
            end
            step();
        end
        m_waitrequest = 1'b0;
        wait_writes(4, 10, ok);
        tests++; if (!ok) begin fails++; $display("FAIL wreq_go_wait got %0d exp 4", wq_a.size()); end
        dma_irq = 1'b1;
        step(); step();
        tests++; if (busy !== 1'b1 || rq_done !== 2'b00) begin
            fails++; $display("FAIL wreq_clrhold got %0b/%0b exp 1/00", busy, rq_done);
        end
        step();
        dma_irq = 1'b0;
        wait_done(1, 10, ok);
        rq_req = 2'b00;
        tests++; if (wq_a.size() != 5) begin fails++; $display("FAIL wreq_nwr got %0d exp 5", wq_a.size()); end
        tests++; if (wq_a[1] != 3 || wq_d[1] !== 32'h6000) begin
            fails++; $display("FAIL wreq_dst got (%0d,%0h) exp (3,6000)", wq_a[1], wq_d[1]);
        end
        tests++; if (wq_c[0] != seen + 1 || wq_c[1] != seen + 5 || wq_c[2] != seen + 6 || wq_c[3] != seen + 7) begin
            fails++; $display("FAIL wreq_cyc got %0d,%0d,%0d,%0d exp %0d,%0d,%0d,%0d", wq_c[0], wq_c[1], wq_c[2], wq_c[3],
                              seen + 1, seen + 5, seen + 6, seen + 7);
        end
        tests++; if (dq_b[0] !== 2'b10 || dq_e[0] !== 2'b00) begin
            fails++; $display("FAIL wreq_done got %0b/%0b exp 10/00", dq_b[0], dq_e[0]);
        end
        tests++; if (dq_c[0] != wq_c[4] + 3) begin
            fails++; $display("FAIL wreq_done_cyc got %0d exp %0d", dq_c[0], wq_c[4] + 3);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit exp;
        clr();
        rq_src0 = 32'h100; rq_dst0 = 32'h200; rq_count0 = 32'd1;
        rq_src1 = 32'h300; rq_dst1 = 32'h400; rq_count1 = 32'd1;
        rq_req = 2'b11;
        step();
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL b2b_first got %0b exp 0", grant); end
        for (int k = 0; k < 4; k++) begin
            exp = k[0];
            wait_writes(5 * k + 4, 20, ok);
            tests++; if (!ok) begin fails++; $display("FAIL b2b_go%0d got %0d writes", k, wq_a.size()); end
            dma_irq = 1'b1; step(); dma_irq = 1'b0;
            wait_done(k + 1, 10, ok);
            tests++;
            if (!ok || dq_b[k] !== (exp ? 2'b10 : 2'b01) || dq_e[k] !== 2'b00) begin
                fails++; $display("FAIL b2b_done%0d got %0b/%0b exp %0b/00", k, dq_b[k], dq_e[k], exp ? 2'b10 : 2'b01);
            end
            if (k < 3) begin
                rq_req[exp] = 1'b0;
                step();
                tests++; if (grant !== !exp) begin fails++; $display("FAIL b2b_grant%0d got %0b exp %0b", k, grant, !exp); end
                rq_req[exp] = 1'b1;
            end else begin
                rq_req = 2'b00;
            end
        end
        step(); step();
        tests++; if (dq_b.size() != 4) begin fails++; $display("FAIL b2b_ndone got %0d exp 4", dq_b.size()); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %0b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel;
        clr();
        rq_src0 = 32'h7000; rq_dst0 = 32'h8000; rq_count0 = 32'd3;
        rq_req = 2'b01;
        wait_writes(4, 12, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmid_go_wait got %0d exp 4", wq_a.size()); end
        clock_sreset = 1'b1;
        step();
        tests++; if (busy !== 1'b0 || grant !== 1'b0 || m_write !== 1'b0) begin
            fails++; $display("FAIL rmid_ctl got %0b,%0b,%0b exp 0,0,0", busy, grant, m_write);
        end
        tests++; if (m_address !== 4'd0 || m_writedata !== 32'd0) begin
            fails++; $display("FAIL rmid_bus got %0h,%0h exp 0,0", m_address, m_writedata);
        end
        tests++; if (rq_done !== 2'b00 || rq_err !== 2'b00) begin
            fails++; $display("FAIL rmid_done got %0b,%0b exp 00,00", rq_done, rq_err);
        end
        step();
        clock_sreset = 1'b0; rel = cyc;
        tests++; if (dq_b.size() != 0 || wq_a.size() != 4) begin
            fails++; $display("FAIL rmid_quiet got %0d done,%0d wr exp 0,4", dq_b.size(), wq_a.size());
        end
        wait_writes(8, 12, ok);
        tests++; if (!ok || wq_a[4] != 2 || wq_c[4] != rel + 1) begin
            fails++; $display("FAIL rmid_rearb got %0d@%0d exp 2@%0d", wq_a[4], wq_c[4], rel + 1);
        end
        dma_irq = 1'b1; step(); dma_irq = 1'b0;
        wait_done(1, 10, ok);
        rq_req = 2'b00;
        tests++; if (!ok || dq_b[0] !== 2'b01 || dq_e[0] !== 2'b00) begin
            fails++; $display("FAIL rmid_done2 got %0b/%0b exp 01/00", dq_b[0], dq_e[0]);
        end
        tests++; if (wq_a.size() != 9 || wq_a[8] != 1 || wq_d[8] !== 32'h2) begin
            fails++; $display("FAIL rmid_clr got n=%0d (%0d,%0h) exp n=9 (1,2)", wq_a.size(), wq_a[8], wq_d[8]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_zero_count();
        test_timeout();
        test_waitreq();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
